// File: rtl/parking_gate_counter.sv
// rtl/parking_gate_counter.sv - two-beam parking gate occupancy counter
module parking_gate_counter #(
   parameter int CAPACITY   = 7,
   parameter int DEB_CYCLES = 4,
   parameter int TIMEOUT    = 1000,
   localparam int CNT_W     = $clog2(CAPACITY + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a,
   input  logic             b,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             enter_p,
   output logic             exit_p,
   output logic             err_p
);

   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);

   typedef enum logic [2:0] {
      IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, WAIT_CLR
   } state_t;

   // index 1 is the outer sensor (a / A), index 0 the inner one (b / B)
   logic [1:0]    sync1, sync2;
   logic [1:0]    ab;
   logic [DW-1:0] deb_cnt [2];
   logic [TW-1:0] timer;
   state_t        state, state_nxt;
   logic          ev_enter, ev_exit, ev_err;
   logic          enter_nxt, exit_nxt, err_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic          pending;

   // two-flop synchronisers; idle level is 1 (beam not blocked)
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1 <= 2'b11;
         sync2 <= 2'b11;
      end else begin
         sync1 <= {a, b};
         sync2 <= sync1;
      end
   end

   // debounce: a flag flips only after DEB_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (!reset) begin
         ab         <= 2'b00;
         deb_cnt[0] <= '0;
         deb_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (~sync2[i] != ab[i]) begin
               if (deb_cnt[i] == DEB_LAST) begin
                  ab[i]      <= ~ab[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + DW'(1);
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   assign pending = (state != IDLE) && (state != WAIT_CLR);

   // passage sequencer, pending timeout and saturating count update
   always_comb begin
      state_nxt = state;
      ev_enter  = 1'b0;
      ev_exit   = 1'b0;
      ev_err    = 1'b0;
      unique case (state)
         IDLE: case (ab)
            2'b10:   state_nxt = IN_A;
            2'b01:   state_nxt = OUT_B;
            2'b11:   begin state_nxt = WAIT_CLR; ev_err = 1'b1; end
            default: ;
         endcase
         IN_A: case (ab)
            2'b11:   state_nxt = IN_AB;
            2'b00:   state_nxt = IDLE;
            2'b01:   begin state_nxt = WAIT_CLR; ev_err = 1'b1; end
            default: ;
         endcase
         IN_AB: case (ab)
            2'b01:   state_nxt = IN_B;
            2'b10:   state_nxt = IN_A;
            2'b00:   begin state_nxt = IDLE; ev_err = 1'b1; end
            default: ;
         endcase
         IN_B: case (ab)
            2'b00:   begin state_nxt = IDLE; ev_enter = 1'b1; end
            2'b11:   state_nxt = IN_AB;
            2'b10:   begin state_nxt = WAIT_CLR; ev_err = 1'b1; end
            default: ;
         endcase
         OUT_B: case (ab)
            2'b11:   state_nxt = OUT_BA;
            2'b00:   state_nxt = IDLE;
            2'b10:   begin state_nxt = WAIT_CLR; ev_err = 1'b1; end
            default: ;
         endcase
         OUT_BA: case (ab)
            2'b10:   state_nxt = OUT_A;
            2'b01:   state_nxt = OUT_B;
            2'b00:   begin state_nxt = IDLE; ev_err = 1'b1; end
            default: ;
         endcase
         OUT_A: case (ab)
            2'b00:   begin state_nxt = IDLE; ev_exit = 1'b1; end
            2'b11:   state_nxt = OUT_BA;
            2'b01:   begin state_nxt = WAIT_CLR; ev_err = 1'b1; end
            default: ;
         endcase
         WAIT_CLR: if (ab == 2'b00) state_nxt = IDLE;
      endcase

      // a real sensor transition wins; timeout only fires when the state would hold
      if (pending && state_nxt == state && timer == TO_LAST) begin
         state_nxt = WAIT_CLR;
         ev_err    = 1'b1;
      end

      enter_nxt = ev_enter && (count != CAP);
      exit_nxt  = ev_exit && (count != '0);
      err_nxt   = ev_err || (ev_enter && count == CAP) || (ev_exit && count == '0);
      count_nxt = count;
      if (enter_nxt) count_nxt = count + CNT_W'(1);
      if (exit_nxt)  count_nxt = count - CNT_W'(1);
   end

   // state, timer, count, flags and pulses; reset abandons any passage
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         timer   <= '0;
         count   <= '0;
         full    <= 1'b0;
         empty   <= 1'b1;
         enter_p <= 1'b0;
         exit_p  <= 1'b0;
         err_p   <= 1'b0;
      end else begin
         state   <= state_nxt;
         if (state_nxt != state || !pending) timer <= '0;
         else                                timer <= timer + TW'(1);
         count   <= count_nxt;
         full    <= (count_nxt == CAP);
         empty   <= (count_nxt == '0);
         enter_p <= enter_nxt;
         exit_p  <= exit_nxt;
         err_p   <= err_nxt;
      end
   end

endmodule
